// File: rtl/pipelined_text_memory.sv
// Instruction memory with LATENCY-stage read pipeline and a credit-counted response FIFO.
// Optional: TEXT_MEM_FAULT_EN adds resp_fault for misaligned requests.
module pipelined_text_memory #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int OUT_DEPTH  = LATENCY + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_BITS-1:0]  req_address,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data
`ifdef TEXT_MEM_FAULT_EN
  ,
  output logic                  resp_fault
`endif
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LB   = $clog2(NB);
  localparam int WA_W = ADDR_BITS - LB;
  localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW   = $clog2(OUT_DEPTH + 1);

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  logic                  vld_q [LATENCY];
  logic [WA_W-1:0]       wa_q  [LATENCY];
  logic [DATA_WIDTH-1:0] fd_q  [OUT_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d, out_q, out_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] rd_word, push_data;
  logic                  fire_req, resp_fire, push, empty;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fire_req  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;
  assign push      = vld_q[LATENCY-1];
  assign empty     = (cnt_q == '0);

  // Credits cover both pipeline and FIFO, so a full count blocks new requests.
  assign req_ready  = (out_q < CW'(OUT_DEPTH));
  assign resp_valid = !empty;
  assign resp_data  = empty ? last_q : fd_q[rd_q];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++)
      rd_word[i*8 +: 8] = mem[{wa_q[LATENCY-1], LB'(i)}];
  end

`ifdef TEXT_MEM_FAULT_EN
  logic flt_q [LATENCY];
  logic ff_q  [OUT_DEPTH];
  assign push_data  = flt_q[LATENCY-1] ? '0 : rd_word;
  assign resp_fault = !empty && ff_q[rd_q];

  always_ff @(posedge clock) begin
    flt_q[0] <= (req_address[LB-1:0] != '0);
    for (int s = 1; s < LATENCY; s++) flt_q[s] <= flt_q[s-1];
    if (push) ff_q[wr_q] <= flt_q[LATENCY-1];
  end
`else
  logic unused_lb;
  assign unused_lb = ^req_address[LB-1:0];
  assign push_data = rd_word;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) vld_q[s] <= 1'b0;
    end else begin
      vld_q[0] <= fire_req;
      for (int s = 1; s < LATENCY; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  always_ff @(posedge clock) begin
    wa_q[0] <= req_address[ADDR_BITS-1:LB];
    for (int s = 1; s < LATENCY; s++) wa_q[s] <= wa_q[s-1];
    if (push) fd_q[wr_q] <= push_data;
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    last_d = last_q;
    if (push) wr_d = wrap_inc(wr_q);
    if (resp_fire) begin
      rd_d   = wrap_inc(rd_q);
      last_d = fd_q[rd_q];
    end
    case ({push, resp_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({fire_req, resp_fire})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      last_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      last_q <= last_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !resp_fire && cnt_q == CW'(OUT_DEPTH)));
  a_credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
    out_q <= CW'(OUT_DEPTH));
`endif

endmodule
